// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// pwm_duty_ramp : synchronised, optionally debounced (DUTY_RAMP_DEBOUNCE_EN),
//                 slew-limited duty setpoint for the PWM generator.
// Revision      : 1.0
// ============================================================================
module pwm_duty_ramp #(
   parameter int DBITS        = 4,
   parameter int DEB_CYCLES   = 16,
   parameter int STEP_PERIODS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DBITS-1:0] sw,
   input  logic             period_wrap,
   output logic [DBITS-1:0] duty,
   output logic             duty_valid,
   output logic             ramping,
   output logic             at_target
);

   localparam logic [7:0]       SCNT_LAST = 8'(STEP_PERIODS - 1);
   localparam logic [DBITS-1:0] DUTY_ONE  = DBITS'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   logic [DBITS-1:0] sync1_q;
   logic [DBITS-1:0] sync2_q;
   logic [DBITS-1:0] target_q, target_d;
   logic [DBITS-1:0] duty_q, duty_d;
   logic [7:0]       scnt_q, scnt_d;
   logic             dv_q, dv_d;
   logic             ramping_q;
   logic             at_target_q;
   state_t           state_q, state_d;

   if ((DEB_CYCLES < 2) || (DEB_CYCLES > 65535) ||
       (STEP_PERIODS < 1) || (STEP_PERIODS > 255)) begin : g_bad_cfg
      $error("pwm_duty_ramp: DEB_CYCLES or STEP_PERIODS out of range");
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
      end
   end

`ifdef DUTY_RAMP_DEBOUNCE_EN
   localparam logic [15:0] DCNT_LAST = 16'(DEB_CYCLES - 1);

   logic [DBITS-1:0] cand_q, cand_d;
   logic [15:0]      dcnt_q, dcnt_d;

   // Any wiggle restarts the count; a stable candidate is promoted once.
   always_comb begin
      cand_d   = cand_q;
      dcnt_d   = dcnt_q;
      target_d = target_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
         if (cand_q != target_q) begin
            target_d = cand_q;
         end
      end else begin
         dcnt_d = dcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_q <= '0;
         dcnt_q <= '0;
      end else begin
         cand_q <= cand_d;
         dcnt_q <= dcnt_d;
      end
   end
`else
   always_comb begin
      target_d = sync2_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         target_q <= '0;
      end else begin
         target_q <= target_d;
      end
   end

   // Steps read target_q, so a same-cycle target update applies to the next step.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      scnt_d  = scnt_q;
      dv_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            scnt_d = '0;
            if (target_q != duty_q) begin
               state_d = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (target_q == duty_q) begin
               state_d = ST_IDLE;
               scnt_d  = '0;
            end else if (period_wrap) begin
               if (scnt_q == SCNT_LAST) begin
                  scnt_d = '0;
                  dv_d   = 1'b1;
                  duty_d = (target_q > duty_q) ? (duty_q + DUTY_ONE)
                                               : (duty_q - DUTY_ONE);
                  if (duty_d == target_q) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  scnt_d = scnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            scnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         duty_q      <= '0;
         scnt_q      <= '0;
         dv_q        <= 1'b0;
         ramping_q   <= 1'b0;
         at_target_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         scnt_q      <= scnt_d;
         dv_q        <= dv_d;
         ramping_q   <= (state_d == ST_RAMP);
         at_target_q <= (state_d == ST_IDLE);
      end
   end

   assign duty       = duty_q;
   assign duty_valid = dv_q;
   assign ramping    = ramping_q;
   assign at_target  = at_target_q;

endmodule
`default_nettype wire

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream stage of the PWM generator. Turns the raw 4-bit switch bank into a glitch-free, slew-limited duty setpoint.
- Processing chain:
  - 2-flop synchroniser on the switches.
  - Optional debounce filter.
  - Ramp engine that moves the output duty one LSB toward the target.
- Duty changes only on PWM period boundaries, signalled by the generator's counter-wrap pulse, so no partial or runt pulses are produced.

Parameters:
- DBITS, 4, width of target and duty; must equal sw width.
- DEB_CYCLES, 16, consecutive stable cycles required before a new switch value is accepted (range 2..65535).
- STEP_PERIODS, 2, PWM period boundaries per one-LSB duty step (range 1..255).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- sw  input  DBITS  asynchronous switch bank, requested duty.
- period_wrap  input  1  one-cycle pulse from the PWM counter when it wraps to 0.
- duty  output  DBITS  registered duty setpoint to the PWM generator.
- duty_valid  output  1  one-cycle strobe, high in the cycle duty holds a new value.
- ramping  output  1  high while duty != target.
- at_target  output  1  registered, equals !ramping.

Behaviour:
- Decided interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values (rst_n low at a posedge):
  - sync flops = 0, debounce counter = 0, target = 0, duty = 0, step counter = 0.
  - duty_valid = 0, ramping = 0, at_target = 1.
  - Reset mid-ramp abandons the ramp; no duty_valid is issued for the reset.
- Synchroniser: sw passes through 2 flops, giving sw_s. Latency 2 cycles.
- Debounce (feature on):
  - Candidate register cand and counter dcnt.
  - If sw_s != cand: cand <= sw_s, dcnt <= 0.
  - Else if dcnt == DEB_CYCLES-1 and cand != target: target <= cand, dcnt holds.
  - Else dcnt increments, saturating at DEB_CYCLES-1.
  - A change is accepted exactly DEB_CYCLES cycles after cand is loaded.
- State machine (2 states):
  - IDLE (duty == target): period_wrap is ignored; step counter held at 0. Go to RAMP in the cycle after target != duty is seen.
  - RAMP: step counter counts period_wrap pulses.
- Duty step:
  - Taken on a period_wrap when scnt == STEP_PERIODS-1; scnt then returns to 0.
  - Direction is computed from the target registered in the previous cycle: duty+1 if target > duty, else duty-1.
  - duty and duty_valid=1 appear at the same edge.
  - After the step, if duty == target: go to IDLE, ramping falls and at_target rises in that same cycle.
- Target change mid-ramp: direction is re-evaluated at each step and scnt is not reset.
  - If the new target equals the current duty: return to IDLE next cycle, no step, no strobe.
- Width rules:
  - duty only moves toward target, so it never wraps; values are unsigned, 0..2^DBITS-1.
  - Compares are unsigned.
- Simultaneous events:
  - A target update and a period_wrap in the same cycle: the step uses the old target.
  - rst_n low overrides everything.
- period_wrap held low keeps duty frozen; ramping stays high.
- duty_valid is never high for two consecutive cycles unless STEP_PERIODS == 1 and period_wrap is high on back-to-back cycles.

Optional Feature:
- Macro: DUTY_RAMP_DEBOUNCE_EN.
- Defined: debounce filter as above.
- Undefined:
  - No cand/dcnt logic.
  - target <= sw_s every cycle, so target follows sw 3 cycles after the change (2 sync + 1 target register).
  - Ramp behaviour is otherwise identical.

Test Plan (DEB_CYCLES=16, STEP_PERIODS=2, period_wrap every 8 cycles, feature on unless stated):
- Ramp up: release reset, hold sw=4'b1000.
  - target=8 about 19 cycles later.
  - duty steps 0,1,...,8 on every 2nd wrap, giving exactly 8 duty_valid strobes.
  - Then at_target=1, ramping=0.
- Bounce rejection: toggle sw between 4'b0001 and 4'b0000 every 5 cycles for 200 cycles.
  - target stays 0, duty stays 0, no duty_valid.
- Reversal: sw=4'b1111; when duty==6, set sw=4'b0010.
  - After the debounce, duty goes 7 (if already committed) or 5, then steps down to 2.
  - Every step is ±1; ends at_target=1.
- Reset mid-ramp: at duty=5, pull rst_n low for one cycle.
  - Next edge: duty=0, target=0, ramping=0, at_target=1, duty_valid=0.
- Stalled wraps: ramping toward 4 with period_wrap held 0 for 100 cycles.
  - duty unchanged, ramping=1, no strobe.
  - The first step occurs on the 2nd wrap after resuming.
- Feature off (DUTY_RAMP_DEBOUNCE_EN undefined): change sw 0→3.
  - target=3 exactly 3 cycles later.
  - duty reaches 3 after 6 wraps.
